qpsk_symbol_mapper: RTL and testbench

- Consumes the 2-bit symbol stream from the 32-bit-to-2-bit converter stage: one symbol per 32-bit beat, symbol in bits [1:0].
- Maps each symbol to a QPSK constellation point as an sc16 sample (I in [31:16], Q in [15:0]).
- Repeats each point SPS times for rectangular upsampling.
- Frames the output into packets of SPP samples using out_tlast, so the stream can feed the RFNoC packetiser and radio TX path.

---
 rtl/qpsk_symbol_mapper.sv | 148 ++++++++++++++
 tb/tb_qpsk_symbol_mapper.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// qpsk_symbol_mapper
//
// Purpose:
//   Maps a stream of 2-bit symbols (one per 32-bit input beat, symbol in
//   bits [1:0]) onto QPSK constellation points. Each point is emitted as an
//   sc16 sample (I in [31:16], Q in [15:0]) and repeated SPS times to give
//   rectangular upsampling. The output is framed into packets of SPP samples
//   with out_tlast, so it can feed a packetiser and radio TX path directly.
//
// Parameters:
//   SPS  samples per symbol (repetition count), 1..256
//   AMP  magnitude of each I/Q component, two's complement 16-bit
//   SPP  samples per output packet, 1..65536
//
// Ports:
//   clk         single clock for all logic
//   reset       synchronous, active-high reset
//   in_tdata    [1:0] symbol, [31:2] ignored
//   in_tvalid   input beat valid
//   in_tready   input beat accepted on in_tvalid && in_tready at a rising edge
//   out_tdata   sc16 sample, I [31:16], Q [15:0]
//   out_tvalid  output sample valid
//   out_tready  downstream ready
//   out_tlast   last sample of a packet, qualified by out_tvalid
// -----------------------------------------------------------------------------
module qpsk_symbol_mapper #(
  parameter int SPS = 4,
  parameter int AMP = 23170,
  parameter int SPP = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast
);

  // Counter widths, never narrower than one bit so SPS=1 / SPP=1 still build.
  localparam int RW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PW = (SPP > 1) ? $clog2(SPP) : 1;

  localparam logic [RW-1:0] REP_MAX = RW'(SPS - 1);
  localparam logic [PW-1:0] PKT_MAX = PW'(SPP - 1);

  localparam logic [15:0] AMP_POS = 16'(AMP);
  localparam logic [15:0] AMP_NEG = 16'(-AMP);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rep_q,   rep_d;
  logic [PW-1:0] pkt_q,   pkt_d;
  logic [31:0]   data_q,  data_d;

  logic        rep_last;
  logic        pkt_last;
  logic        accept;
  logic        out_hs;
  logic [31:0] mapped;

  // Upper input bits carry no information for this stage.
  logic unused_upper;
  assign unused_upper = ^in_tdata[31:2];

  // With SPS=1 the counter is pinned at 0, so this is always true.
  assign rep_last = (rep_q == REP_MAX);
  assign pkt_last = (pkt_q == PKT_MAX);

  assign out_tvalid = (state_q == EMIT);
  assign out_tdata  = data_q;
  assign out_tlast  = out_tvalid && pkt_last;

  // Ready is combinational from out_tready: the next symbol is taken in the
  // same cycle the final repeat of the current one is consumed, leaving no
  // bubble between symbols.
  assign in_tready = (state_q == IDLE) || (out_tready && rep_last);

  assign accept = in_tvalid && in_tready;
  assign out_hs = out_tvalid && out_tready;

  // Sign selection only; bit 1 picks the I sign, bit 0 the Q sign.
  assign mapped = {in_tdata[1] ? AMP_NEG : AMP_POS,
                   in_tdata[0] ? AMP_NEG : AMP_POS};

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    state_d = state_q;
    rep_d   = rep_q;
    pkt_d   = pkt_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = mapped;
          rep_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (!rep_last) begin
            rep_d = rep_q + RW'(1);
          end else if (accept) begin
            data_d = mapped;
            rep_d  = '0;
          end else begin
            rep_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Packet framing counts handshakes only and ignores symbol boundaries,
    // so it carries across IDLE gaps.
    if (out_hs) begin
      pkt_d = pkt_last ? '0 : pkt_q + PW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rep_q   <= '0;
      pkt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      pkt_q   <= pkt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_qpsk_symbol_mapper
//
// Purpose:
//   Self-checking bench for qpsk_symbol_mapper. Two instances are used: one
//   with SPS=4 and one with SPS=1, both with SPP=64. A reference model per
//   instance keeps a queue of expected samples (each accepted symbol expands
//   into SPS copies of its constellation point) and a global sample index
//   since reset that determines where out_tlast must fall.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_qpsk_symbol_mapper;

  localparam int SPS4 = 4;
  localparam int SPS1 = 1;
  localparam int SPP  = 64;
  localparam int AMP  = 23170;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] in_tdata4,  in_tdata1;
  logic        in_tvalid4, in_tvalid1;
  logic        in_tready4, in_tready1;
  logic [31:0] out_tdata4, out_tdata1;
  logic        out_tvalid4, out_tvalid1;
  logic        out_tready4, out_tready1;
  logic        out_tlast4, out_tlast1;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  qpsk_symbol_mapper #(.SPS(SPS4), .AMP(AMP), .SPP(SPP)) u_sps4 (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (in_tdata4),
    .in_tvalid  (in_tvalid4),
    .in_tready  (in_tready4),
    .out_tdata  (out_tdata4),
    .out_tvalid (out_tvalid4),
    .out_tready (out_tready4),
    .out_tlast  (out_tlast4)
  );

  qpsk_symbol_mapper #(.SPS(SPS1), .AMP(AMP), .SPP(SPP)) u_sps1 (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (in_tdata1),
    .in_tvalid  (in_tvalid1),
    .in_tready  (in_tready1),
    .out_tdata  (out_tdata1),
    .out_tvalid (out_tvalid1),
    .out_tready (out_tready1),
    .out_tlast  (out_tlast1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Constellation point from the mapping rule, using plain signed arithmetic.
  function automatic logic [31:0] ref_point(input logic [1:0] sym);
    int i_v;
    int q_v;
    i_v = sym[1] ? -AMP : AMP;
    q_v = sym[0] ? -AMP : AMP;
    return {16'(i_v), 16'(q_v)};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model + monitor, SPS=4 instance. Sampled on the falling edge,
  // i.e. the values that the next rising edge will act on.
  // ---------------------------------------------------------------------------
  logic [31:0] exp4_q[$];
  logic [31:0] log4_q[$];
  int          log4_cyc[$];
  int          acc4_cyc[$];
  int          tl4_q[$];
  int          gcnt4;
  int          pend4;
  bit          stall4;
  logic [31:0] stall_data4;
  logic        stall_last4;

  always @(negedge clk) begin
    if (reset) begin
      exp4_q.delete();
      gcnt4  = 0;
      stall4 = 1'b0;
    end else begin
      pend4 = exp4_q.size();
      check("u4 out_tvalid", 32'(out_tvalid4), 32'(pend4 > 0));
      check("u4 in_tready", 32'(in_tready4),
            32'((pend4 == 0) || (pend4 == 1 && out_tready4)));
      if (!out_tvalid4) check("u4 tlast while idle", 32'(out_tlast4), 32'd0);
      if (out_tvalid4 && stall4) begin
        check("u4 stall data", out_tdata4, stall_data4);
        check("u4 stall tlast", 32'(out_tlast4), 32'(stall_last4));
      end
      stall4      = out_tvalid4 && !out_tready4;
      stall_data4 = out_tdata4;
      stall_last4 = out_tlast4;
      if (out_tvalid4 && out_tready4) begin
        if (exp4_q.size() == 0) begin
          check("u4 spurious sample", 32'(out_tvalid4), 32'd0);
        end else begin
          check("u4 sample", out_tdata4, exp4_q.pop_front());
          check("u4 tlast", 32'(out_tlast4), 32'((gcnt4 % SPP) == SPP - 1));
          log4_q.push_back(out_tdata4);
          log4_cyc.push_back(cyc);
          if (out_tlast4) tl4_q.push_back(gcnt4 + 1);
          gcnt4++;
        end
      end
      if (in_tvalid4 && in_tready4) begin
        acc4_cyc.push_back(cyc);
        repeat (SPS4) exp4_q.push_back(ref_point(in_tdata4[1:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model + monitor, SPS=1 instance.
  // ---------------------------------------------------------------------------
  logic [31:0] exp1_q[$];
  int          tl1_q[$];
  int          gcnt1;
  int          pend1;
  int          n1;
  int          nr1;

  always @(negedge clk) begin
    if (reset) begin
      exp1_q.delete();
      gcnt1 = 0;
    end else begin
      pend1 = exp1_q.size();
      check("u1 out_tvalid", 32'(out_tvalid1), 32'(pend1 > 0));
      check("u1 in_tready", 32'(in_tready1),
            32'((pend1 == 0) || (pend1 == 1 && out_tready1)));
      if (in_tvalid1 && !in_tready1) nr1++;
      if (out_tvalid1 && out_tready1) begin
        if (exp1_q.size() == 0) begin
          check("u1 spurious sample", 32'(out_tvalid1), 32'd0);
        end else begin
          check("u1 sample", out_tdata1, exp1_q.pop_front());
          check("u1 tlast", 32'(out_tlast1), 32'((gcnt1 % SPP) == SPP - 1));
          if (out_tlast1) tl1_q.push_back(gcnt1 + 1);
          n1++;
          gcnt1++;
        end
      end
      if (in_tvalid1 && in_tready1) begin
        repeat (SPS1) exp1_q.push_back(ref_point(in_tdata1[1:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    in_tvalid4 = 1'b1;
    in_tdata4  = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_tready4) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("u4 accept timeout", 32'(in_tready4), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs4();
    log4_q.delete();
    log4_cyc.delete();
    acc4_cyc.delete();
    tl4_q.delete();
  endtask

  logic [31:0] t1_exp [4];

  initial begin
    t1_exp = '{32'h5A825A82, 32'h5A82A57E, 32'hA57E5A82, 32'hA57EA57E};
    n1  = 0;
    nr1 = 0;

    // Reset state.
    reset       = 1'b1;
    in_tvalid4  = 1'b0;
    in_tdata4   = '0;
    in_tvalid1  = 1'b0;
    in_tdata1   = '0;
    out_tready4 = 1'b1;
    out_tready1 = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset u4 out_tvalid", 32'(out_tvalid4), 32'd0);
    check("reset u4 out_tdata", out_tdata4, 32'd0);
    check("reset u4 out_tlast", 32'(out_tlast4), 32'd0);
    check("reset u4 in_tready", 32'(in_tready4), 32'd1);
    check("reset u1 out_tvalid", 32'(out_tvalid1), 32'd0);
    check("reset u1 in_tready", 32'(in_tready1), 32'd1);

    // Symbols 0..3 back to back, SPS=4.
    clear_logs4();
    for (int s = 0; s < 4; s++) send4(32'(s));
    in_tvalid4 = 1'b0;
    repeat (20) step();
    check("t1 sample count", 32'(log4_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < log4_q.size(); i++)
      check($sformatf("t1 sample %0d", i), log4_q[i], t1_exp[i / 4]);
    if (log4_cyc.size() >= 16 && acc4_cyc.size() >= 1) begin
      check("t1 no gaps", 32'(log4_cyc[15] - log4_cyc[0]), 32'd15);
      check("t1 first latency", 32'(log4_cyc[0] - acc4_cyc[0]), 32'd1);
    end

    // Upper input bits ignored.
    clear_logs4();
    send4({30'h3FFF_FFFF, 2'b00});
    in_tvalid4 = 1'b0;
    repeat (8) step();
    check("upper bits count", 32'(log4_q.size()), 32'd4);
    if (log4_q.size() >= 4) begin
      check("upper bits first", log4_q[0], 32'h5A825A82);
      check("upper bits last", log4_q[3], 32'h5A825A82);
    end

    // Input stall: one symbol, 10 idle cycles, another symbol.
    send4(32'($urandom_range(0, 3)));
    in_tvalid4 = 1'b0;
    repeat (10) step();
    check("gap out_tvalid", 32'(out_tvalid4), 32'd0);
    check("gap in_tready", 32'(in_tready4), 32'd1);
    send4(32'($urandom_range(0, 3)));
    in_tvalid4 = 1'b0;
    repeat (6) step();

    // Random in_tvalid and out_tready.
    clear_logs4();
    for (int c = 0; c < 600; c++) begin
      in_tvalid4  = 1'($urandom_range(0, 1));
      in_tdata4   = $urandom;
      out_tready4 = 1'($urandom_range(0, 1));
      step();
    end
    in_tvalid4  = 1'b0;
    out_tready4 = 1'b1;
    repeat (20) step();
    check("random drained", 32'(exp4_q.size()), 32'd0);
    check("random no loss/dup", 32'(log4_q.size()), 32'(acc4_cyc.size() * SPS4));

    // SPS=1, continuous input for 200 cycles.
    tl1_q.delete();
    n1  = 0;
    nr1 = 0;
    in_tvalid1 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      in_tdata1 = $urandom;
      step();
    end
    in_tvalid1 = 1'b0;
    repeat (5) step();
    check("sps1 sample count", 32'(n1), 32'd200);
    check("sps1 in_tready low cycles", 32'(nr1), 32'd0);
    check("sps1 tlast count", 32'(tl1_q.size()), 32'd3);
    if (tl1_q.size() >= 3) begin
      check("sps1 tlast 1", 32'(tl1_q[0]), 32'd64);
      check("sps1 tlast 2", 32'(tl1_q[1]), 32'd128);
      check("sps1 tlast 3", 32'(tl1_q[2]), 32'd192);
    end

    // Reset during the 3rd repeat of a symbol, at sample 30 of a packet.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    in_tvalid4 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (gcnt4 == 30) break;
      in_tdata4 = $urandom;
      step();
    end
    check("reach sample 30", 32'(gcnt4), 32'd30);
    reset      = 1'b1;
    in_tvalid4 = 1'b0;
    step();
    reset = 1'b0;
    check("mid reset out_tvalid", 32'(out_tvalid4), 32'd0);
    check("mid reset in_tready", 32'(in_tready4), 32'd1);
    check("mid reset out_tlast", 32'(out_tlast4), 32'd0);
    clear_logs4();
    for (int s = 0; s < 17; s++) send4($urandom);
    in_tvalid4 = 1'b0;
    repeat (10) step();
    check("post reset samples", 32'(log4_q.size()), 32'd68);
    if (tl4_q.size() >= 1) check("post reset tlast index", 32'(tl4_q[0]), 32'd64);
    else check("post reset tlast seen", 32'(tl4_q.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
